// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback over a shared variable-latency
// memory port, with a wait timeout and a retired-instruction counter.
module mc_ctrl #(
    parameter int TO_W   = 8,
    parameter int TO_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemRead,
    output logic [1:0]  MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        EXTOp,
    output logic [3:0]  ALUOp,
    output logic [1:0]  NPCOp,
    output logic        ALUSrc,
    output logic [1:0]  GPRSel,
    output logic [1:0]  WDSel,
    output logic [2:0]  LAddr,
    output logic        instr_done,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_ALUWB  = 4'd4,
        S_ADDR   = 4'd5,
        S_MEMRD  = 4'd6,
        S_LDWB   = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Last counter value before a stalled access is declared hung.
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_MAX - 1);

    // ALU code for an R-type function field; 0000 marks an unsupported funct.
    function automatic logic [3:0] r_alu_op(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001: r_alu_op = 4'b0001; // add, addu
            6'b100010, 6'b100011: r_alu_op = 4'b0010; // sub, subu
            6'b100100:            r_alu_op = 4'b0011; // and
            6'b100101:            r_alu_op = 4'b0100; // or
            6'b101010:            r_alu_op = 4'b0101; // slt
            6'b101011:            r_alu_op = 4'b0110; // sltu
            6'b100111:            r_alu_op = 4'b1000; // nor
            6'b100110:            r_alu_op = 4'b1001; // xor
            6'b000110:            r_alu_op = 4'b1010; // srlv
            6'b000100:            r_alu_op = 4'b1011; // sllv
            6'b000111:            r_alu_op = 4'b1100; // srav
            default:              r_alu_op = 4'b0000;
        endcase
    endfunction

    // ALU code for an ALU-immediate opcode; 0000 means not an ALU immediate.
    function automatic logic [3:0] i_alu_op(input logic [5:0] op);
        case (op)
            OP_ADDI: i_alu_op = 4'b0001;
            OP_ANDI: i_alu_op = 4'b0011;
            OP_ORI:  i_alu_op = 4'b0100;
            OP_SLTI: i_alu_op = 4'b0101;
            OP_LUI:  i_alu_op = 4'b1101;
            default: i_alu_op = 4'b0000;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic [31:0]       instr_cnt_q, instr_cnt_d;

    logic              is_r, is_alui, is_load, is_store;
    logic              is_beq, is_bne, is_jal, is_jmp, dec_ok, imm_sext;
    logic [3:0]        alu_dec;
    logic [2:0]        laddr_dec;
    logic [1:0]        mw_dec;
    logic              wait_st;

    assign is_r     = (Op == OP_RTYPE);
    assign is_alui  = (i_alu_op(Op) != 4'b0000);
    assign is_load  = (Op == OP_LW) || (Op == OP_LB) || (Op == OP_LH) ||
                      (Op == OP_LBU) || (Op == OP_LHU);
    assign is_store = (Op == OP_SW) || (Op == OP_SB) || (Op == OP_SH);
    assign is_beq   = (Op == OP_BEQ);
    assign is_bne   = (Op == OP_BNE);
    assign is_jal   = (Op == OP_JAL);
    assign is_jmp   = (Op == OP_J) || is_jal;
    assign dec_ok   = (is_r && (r_alu_op(Funct) != 4'b0000)) || is_alui ||
                      is_load || is_store || is_beq || is_bne || is_jmp;
    assign alu_dec  = is_r ? r_alu_op(Funct) : i_alu_op(Op);
    // Only the arithmetic/compare immediates sign-extend; logical ones and lui do not.
    assign imm_sext = (Op == OP_ADDI) || (Op == OP_SLTI);
    assign wait_st  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);

    // Load-type and store-size selects from the opcode.
    always_comb begin
        laddr_dec = 3'b000;
        mw_dec    = 2'b00;
        case (Op)
            OP_LB:   laddr_dec = 3'b001;
            OP_LBU:  laddr_dec = 3'b010;
            OP_LH:   laddr_dec = 3'b011;
            OP_LHU:  laddr_dec = 3'b100;
            OP_SW:   mw_dec    = 2'b01;
            OP_SB:   mw_dec    = 2'b10;
            OP_SH:   mw_dec    = 2'b11;
            default: ;
        endcase
    end

    // Datapath controls decoded from the current state and instruction.
    always_comb begin
        mem_req    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 2'b00;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        EXTOp      = 1'b0;
        ALUOp      = 4'b0000;
        NPCOp      = 2'b00;
        ALUSrc     = 1'b0;
        GPRSel     = 2'b00;
        WDSel      = 2'b00;
        LAddr      = 3'b000;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                illegal    = ~dec_ok;
                instr_done = ~dec_ok;
            end
            S_EXEC: begin
                ALUOp  = alu_dec;
                ALUSrc = ~is_r;
                EXTOp  = imm_sext;
            end
            S_ALUWB: begin
                ALUOp      = alu_dec;
                ALUSrc     = ~is_r;
                EXTOp      = imm_sext;
                RegWrite   = 1'b1;
                GPRSel     = is_r ? 2'b00 : 2'b01;
                instr_done = 1'b1;
            end
            S_ADDR: begin
                ALUOp  = 4'b0001;
                ALUSrc = 1'b1;
                EXTOp  = 1'b1;
            end
            S_MEMRD: begin
                ALUOp   = 4'b0001;
                ALUSrc  = 1'b1;
                EXTOp   = 1'b1;
                mem_req = 1'b1;
                MemRead = 1'b1;
                LAddr   = laddr_dec;
            end
            S_LDWB: begin
                RegWrite   = 1'b1;
                WDSel      = 2'b01;
                GPRSel     = 2'b01;
                LAddr      = laddr_dec;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                ALUOp      = 4'b0001;
                ALUSrc     = 1'b1;
                EXTOp      = 1'b1;
                mem_req    = 1'b1;
                MemWrite   = mw_dec;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                ALUOp      = 4'b0010;
                EXTOp      = 1'b1;
                NPCOp      = 2'b01;
                PCWrite    = (is_beq & Zero) | (is_bne & ~Zero);
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                NPCOp      = 2'b10;
                RegWrite   = is_jal;
                GPRSel     = is_jal ? 2'b10 : 2'b00;
                WDSel      = is_jal ? 2'b10 : 2'b00;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus_err   = bus_err_q;
    assign instr_cnt = instr_cnt_q;

    // Next state, wait timeout and retired-instruction count.
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = '0;
        bus_err_d   = bus_err_q;
        instr_cnt_d = instr_done ? instr_cnt_q + 32'd1 : instr_cnt_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!dec_ok)                    state_d = S_FETCH;
                else if (is_load || is_store)   state_d = S_ADDR;
                else if (is_beq || is_bne)      state_d = S_BRANCH;
                else if (is_jmp)                state_d = S_JUMP;
                else                            state_d = S_EXEC;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_ADDR:   state_d = is_load ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_LDWB;
            S_LDWB:   state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        // A stall that reaches the limit overrides the normal transition;
        // a ready in that same cycle never gets here.
        if (wait_st && !mem_ready) begin
            if (to_cnt_q == TO_LIM) begin
                state_d   = S_HALT;
                bus_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            to_cnt_q    <= '0;
            bus_err_q   <= 1'b0;
            instr_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            bus_err_q   <= bus_err_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle control vectors checked against
// hand-computed expectations for each instruction class and the timeout.
module tb_mc_ctrl;

    logic        clk, rst;
    logic [5:0]  Op, Funct;
    logic        Zero, mem_ready;
    logic        mem_req, MemRead, IRWrite, PCWrite, RegWrite, EXTOp, ALUSrc;
    logic [1:0]  MemWrite, NPCOp, GPRSel, WDSel;
    logic [3:0]  ALUOp;
    logic [2:0]  LAddr;
    logic        instr_done, illegal, bus_err;
    logic [31:0] instr_cnt;

    int checks   = 0;
    int failures = 0;

    logic [24:0] ctl;
    logic [24:0] fw, fr;

    assign ctl = {mem_req, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, EXTOp,
                  ALUOp, NPCOp, ALUSrc, GPRSel, WDSel, LAddr, instr_done,
                  illegal, bus_err};

    mc_ctrl #(.TO_W(8), .TO_MAX(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .ALUSrc(ALUSrc), .GPRSel(GPRSel), .WDSel(WDSel), .LAddr(LAddr),
        .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err),
        .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs named control fields in the same order as ctl.
    function automatic logic [24:0] pk(input int mr, input int rd, input int mw,
        input int irw, input int pcw, input int rw, input int ext, input int alu,
        input int npc, input int src, input int gpr, input int wd, input int la,
        input int done, input int ill, input int be);
        pk = {mr[0], rd[0], mw[1:0], irw[0], pcw[0], rw[0], ext[0], alu[3:0],
              npc[1:0], src[0], gpr[1:0], wd[1:0], la[2:0], done[0], ill[0], be[0]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_ready = 1'b0;
        #3;
        checks++;
        if (ctl !== 25'd0) begin failures++; $display("FAIL reset_ctl got=%h exp=%h", ctl, 25'd0); end
        checks++;
        if (instr_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", instr_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 25'd0) begin failures++; $display("FAIL reset_idle got=%h exp=%h", ctl, 25'd0); end
    endtask

    task automatic test_add();
        logic [24:0] ex [5];
        do_reset();
        Op = 6'b000000; Funct = 6'b100000; Zero = 1'b0; mem_ready = 1'b1;
        ex = '{25'd0, fr, 25'd0,
               pk(0,0,0,0,0,0,0,4'b0001,0,0,0,0,0,0,0,0),
               pk(0,0,0,0,0,1,0,4'b0001,0,0,0,0,0,1,0,0)};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== ex[i]) begin failures++; $display("FAIL add step%0d got=%h exp=%h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (instr_cnt !== 32'd1) begin failures++; $display("FAIL add_cnt got=%0d exp=1", instr_cnt); end
    endtask

    task automatic test_alu();
        logic [24:0] ex [13];
        logic [5:0]  op [13];
        logic [5:0]  fn [13];
        do_reset();
        mem_ready = 1'b1; Zero = 1'b0;
        op = '{6'b001101, 6'b001101, 6'b001101, 6'b001101, 6'b001101,
               6'b001000, 6'b001000, 6'b001000, 6'b001000,
               6'b000000, 6'b000000, 6'b000000, 6'b000000};
        fn = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
               6'b100110, 6'b100110, 6'b100110, 6'b100110};
        ex = '{25'd0, fr, 25'd0,
               pk(0,0,0,0,0,0,0,4'b0100,0,1,0,0,0,0,0,0),
               pk(0,0,0,0,0,1,0,4'b0100,0,1,1,0,0,1,0,0),
               fr, 25'd0,
               pk(0,0,0,0,0,0,1,4'b0001,0,1,0,0,0,0,0,0),
               pk(0,0,0,0,0,1,1,4'b0001,0,1,1,0,0,1,0,0),
               fr, 25'd0,
               pk(0,0,0,0,0,0,0,4'b1001,0,0,0,0,0,0,0,0),
               pk(0,0,0,0,0,1,0,4'b1001,0,0,0,0,0,1,0,0)};
        for (int i = 0; i < 13; i++) begin
            Op = op[i]; Funct = fn[i];
            @(negedge clk);
            checks++;
            if (ctl !== ex[i]) begin failures++; $display("FAIL alu step%0d got=%h exp=%h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (instr_cnt !== 32'd3) begin failures++; $display("FAIL alu_cnt got=%0d exp=3", instr_cnt); end
    endtask

    task automatic test_lhu();
        logic [24:0] ex [11];
        int          rd [11];
        int          dones;
        logic [24:0] mrd;
        dones = 0;
        do_reset();
        Op = 6'b100101; Funct = 6'd0; Zero = 1'b0;
        mrd = pk(1,1,0,0,0,0,1,4'b0001,0,1,0,0,3'b100,0,0,0);
        rd = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        ex = '{25'd0, fw, fw, fw, fr, 25'd0,
               pk(0,0,0,0,0,0,1,4'b0001,0,1,0,0,0,0,0,0),
               mrd, mrd,
               pk(0,0,0,0,0,1,0,0,0,0,1,1,3'b100,1,0,0),
               fw};
        for (int i = 0; i < 11; i++) begin
            mem_ready = rd[i][0];
            @(negedge clk);
            if (instr_done) dones++;
            checks++;
            if (ctl !== ex[i]) begin failures++; $display("FAIL lhu step%0d got=%h exp=%h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        checks++;
        if (dones !== 1) begin failures++; $display("FAIL lhu_done_pulses got=%0d exp=1", dones); end
        @(negedge clk);
        checks++;
        if (instr_cnt !== 32'd1) begin failures++; $display("FAIL lhu_cnt got=%0d exp=1", instr_cnt); end
    endtask

    task automatic test_sh();
        logic [24:0] ex [8];
        int          rd [8];
        int          rw_seen;
        logic [24:0] mwr;
        rw_seen = 0;
        do_reset();
        Op = 6'b101001; Funct = 6'd0; Zero = 1'b0;
        mwr = pk(1,0,2'b11,0,0,0,1,4'b0001,0,1,0,0,0,0,0,0);
        rd = '{0, 1, 0, 0, 0, 0, 1, 0};
        ex = '{25'd0, fr, 25'd0,
               pk(0,0,0,0,0,0,1,4'b0001,0,1,0,0,0,0,0,0),
               mwr, mwr, mwr | 25'd4, fw};
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd[i][0];
            @(negedge clk);
            if (RegWrite) rw_seen++;
            checks++;
            if (ctl !== ex[i]) begin failures++; $display("FAIL sh step%0d got=%h exp=%h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        checks++;
        if (rw_seen !== 0) begin failures++; $display("FAIL sh_regwrite got=%0d exp=0", rw_seen); end
    endtask

    task automatic test_branch();
        logic [24:0] ex [17];
        logic [5:0]  op [17];
        int          zf [17];
        do_reset();
        Funct = 6'd0; mem_ready = 1'b1;
        op = '{6'b000100, 6'b000100, 6'b000100, 6'b000100,
               6'b000101, 6'b000101, 6'b000101,
               6'b000101, 6'b000101, 6'b000101,
               6'b000011, 6'b000011, 6'b000011,
               6'b000010, 6'b000010, 6'b000010, 6'b000010};
        zf = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ex = '{25'd0, fr, 25'd0,
               pk(0,0,0,0,1,0,1,4'b0010,1,0,0,0,0,1,0,0),
               fr, 25'd0,
               pk(0,0,0,0,0,0,1,4'b0010,1,0,0,0,0,1,0,0),
               fr, 25'd0,
               pk(0,0,0,0,1,0,1,4'b0010,1,0,0,0,0,1,0,0),
               fr, 25'd0,
               pk(0,0,0,0,1,1,0,0,2'b10,0,2'b10,2'b10,0,1,0,0),
               fr, 25'd0,
               pk(0,0,0,0,1,0,0,0,2'b10,0,0,0,0,1,0,0),
               fr};
        for (int i = 0; i < 17; i++) begin
            Op = op[i]; Zero = zf[i][0];
            @(negedge clk);
            checks++;
            if (ctl !== ex[i]) begin failures++; $display("FAIL branch step%0d got=%h exp=%h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (instr_cnt !== 32'd5) begin failures++; $display("FAIL branch_cnt got=%0d exp=5", instr_cnt); end
    endtask

    task automatic test_illegal();
        logic [24:0] ex [6];
        logic [5:0]  op [6];
        logic [5:0]  fn [6];
        int          rd [6];
        do_reset();
        Zero = 1'b0;
        op = '{6'b111111, 6'b111111, 6'b111111, 6'b000000, 6'b000000, 6'b000000};
        fn = '{6'd0, 6'd0, 6'd0, 6'b111111, 6'b111111, 6'b111111};
        rd = '{1, 1, 1, 1, 1, 0};
        ex = '{25'd0, fr, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0),
               fr, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0), fw};
        for (int i = 0; i < 6; i++) begin
            Op = op[i]; Funct = fn[i]; mem_ready = rd[i][0];
            @(negedge clk);
            checks++;
            if (ctl !== ex[i]) begin failures++; $display("FAIL illegal step%0d got=%h exp=%h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (instr_cnt !== 32'd2) begin failures++; $display("FAIL illegal_cnt got=%0d exp=2", instr_cnt); end
    endtask

    task automatic test_timeout();
        logic [24:0] ex [7];
        int          rd [7];
        logic [24:0] halt_v;
        do_reset();
        Op = 6'b000000; Funct = 6'b100000; Zero = 1'b0;
        halt_v = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
        rd = '{0, 0, 0, 0, 0, 1, 0};
        ex = '{25'd0, fw, fw, fw, fw, halt_v, halt_v};
        for (int i = 0; i < 7; i++) begin
            mem_ready = rd[i][0];
            @(negedge clk);
            checks++;
            if (ctl !== ex[i]) begin failures++; $display("FAIL timeout step%0d got=%h exp=%h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 25'd0) begin failures++; $display("FAIL timeout_rst got=%h exp=%h", ctl, 25'd0); end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 25'd0) begin failures++; $display("FAIL timeout_idle got=%h exp=%h", ctl, 25'd0); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ctl !== fw) begin failures++; $display("FAIL timeout_refetch got=%h exp=%h", ctl, fw); end
    endtask

    task automatic test_abort();
        logic [24:0] ex [5];
        do_reset();
        Op = 6'b100011; Funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
        ex = '{25'd0, fr, 25'd0,
               pk(0,0,0,0,0,0,1,4'b0001,0,1,0,0,0,0,0,0),
               pk(1,1,0,0,0,0,1,4'b0001,0,1,0,0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            if (i == 4) mem_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (ctl !== ex[i]) begin failures++; $display("FAIL abort step%0d got=%h exp=%h", i, ctl, ex[i]); end
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 25'd0) begin failures++; $display("FAIL abort_ctl got=%h exp=%h", ctl, 25'd0); end
        checks++;
        if (instr_cnt !== 32'd0) begin failures++; $display("FAIL abort_cnt got=%0d exp=0", instr_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        fw = pk(1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        fr = pk(1,1,0,1,1,0,0,0,0,0,0,0,0,0,0,0);
        test_reset();
        test_add();
        test_alu();
        test_lhu();
        test_sh();
        test_branch();
        test_illegal();
        test_timeout();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
